// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder datapath (source, adder, deserializer).
package bit_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_deserializer.sv
// Collects an LSB-first serial stream into a WIDTH-bit word and offers it on a
// valid/ready handshake.
module bit_serial_deserializer
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;
  logic             frame_done;

  assign shifted = {bit_in, shreg_q[WIDTH-1:1]};

  // Single end-of-frame strobe shared by the FSM and the data_out load.
  assign frame_done = (state_q == StShift) && !start && bit_valid &&
                      (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (start) begin
          // Abort: the bit presented this cycle is dropped with the frame.
          shreg_d = '0;
          cnt_d   = '0;
        end else if (frame_done) begin
          shreg_d = shifted;
          data_d  = shifted;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StHold;
        end else if (bit_valid) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StShift);
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_bit_serial_deserializer.sv
// Directed bench for bit_serial_deserializer: scoreboard queue of expected words
// checked by a handshake monitor, plus inline checks of status outputs.
module tb_bit_serial_deserializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb[$];

  bit_serial_deserializer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .busy     (busy),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: at the falling edge the handshake the next rising edge will sample is visible.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0h expected none", data_out);
      end else begin
        chk("sb_data_out", 32'(data_out), 32'(sb.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] pat;

  initial begin
    pat       = 8'h4D;  // stream 1,0,1,1,0,0,1,0 LSB first
    rst       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      start     = 1'($urandom);
      bit_in    = 1'($urandom);
      bit_valid = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_bit_count", 32'(bit_count), 32'h0);
    end
    rst       = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Basic frame
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_busy_after_start", 32'(busy), 32'h1);
    chk("basic_count_after_start", 32'(bit_count), 32'h0);
    sb.push_back(8'h4D);
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i]);
      if (i < 7) chk("basic_bit_count", 32'(bit_count), 32'(i + 1));
    end
    chk("basic_out_valid", 32'(out_valid), 32'h1);
    chk("basic_data_out", 32'(data_out), 32'h4D);
    chk("basic_busy_hold", 32'(busy), 32'h0);
    chk("basic_count_hold", 32'(bit_count), 32'h0);
    tick();
    chk("basic_valid_drop", 32'(out_valid), 32'h0);

    // Gaps in bit_valid
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(8'h4D);
    for (int i = 0; i < 4; i++) send_bit(pat[i]);
    for (int i = 0; i < 3; i++) begin
      bit_in = ~bit_in;
      tick();
      chk("gap_count_hold", 32'(bit_count), 32'h4);
      chk("gap_data_unchanged", 32'(data_out), 32'h4D);
    end
    for (int i = 4; i < 8; i++) send_bit(pat[i]);
    chk("gap_out_valid", 32'(out_valid), 32'h1);
    chk("gap_data_out", 32'(data_out), 32'h4D);
    tick();

    // Back-pressure
    out_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(8'h4D);
    for (int i = 0; i < 8; i++) send_bit(pat[i]);
    for (int i = 0; i < 5; i++) begin
      bit_in    = 1'(i);
      bit_valid = ~bit_valid;
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_data_out", 32'(data_out), 32'h4D);
      chk("bp_busy", 32'(busy), 32'h0);
    end
    bit_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(out_valid), 32'h0);
    chk("bp_idle_busy", 32'(busy), 32'h0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("bp_idle_ignores_bits", 32'(bit_count), 32'h0);
    chk("bp_idle_busy2", 32'(busy), 32'h0);

    // Restart mid-frame, completion held under back-pressure
    out_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("restart_count_before", 32'(bit_count), 32'h3);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("restart_count_cleared", 32'(bit_count), 32'h0);
    chk("restart_busy", 32'(busy), 32'h1);
    chk("restart_data_unchanged", 32'(data_out), 32'h4D);
    sb.push_back(8'hFF);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    chk("restart_out_valid", 32'(out_valid), 32'h1);
    chk("restart_data_out", 32'(data_out), 32'hFF);

    // start + bit_valid + out_ready together in HOLD
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("hold_restart_valid", 32'(out_valid), 32'h0);
    chk("hold_restart_busy", 32'(busy), 32'h1);
    chk("hold_restart_count", 32'(bit_count), 32'h0);

    // Mid-frame reset
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("mrst_count_before", 32'(bit_count), 32'h5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'(i));
      chk("mrst_bit_count", 32'(bit_count), 32'h0);
      chk("mrst_out_valid", 32'(out_valid), 32'h0);
      chk("mrst_data_out", 32'(data_out), 32'h0);
    end

    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_deserializer.md
# bit_serial_deserializer

Receive end of the bit-serial adder datapath. It collects the serial sum stream, LSB first, one bit per qualified clock, into a WIDTH-bit parallel word. It then presents the word on a valid/ready output handshake. It is the counterpart of the parallel-to-serial shift source that feeds the serial full adder.

## Interface
Parameters:
- WIDTH, 8, number of serial bits per word (>= 2)
- CNT_W, $clog2(WIDTH+1), width of bit_count (derived, not overridden)

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin or restart a frame
- bit_in  in  1  serial data bit, LSB first
- bit_valid  in  1  bit_in qualifier
- out_ready  in  1  downstream accepts data_out
- data_out  out  WIDTH  assembled word, stable while out_valid
- out_valid  out  1  word available
- busy  out  1  high in SHIFT state
- bit_count  out  CNT_W  bits accepted in current frame

## Operation
- States are IDLE, SHIFT and HOLD. Reset state is IDLE.
- IDLE:
  - start=1 → clear the shift register and bit_count, go to SHIFT.
  - bit_valid is ignored.
- SHIFT: each cycle with bit_valid=1, shreg <= {bit_in, shreg[WIDTH-1:1]} and bit_count increments.
- Accepting the WIDTH-th bit:
  - data_out <= the final shifted word, with the first received bit in bit 0.
  - out_valid <= 1.
  - bit_count <= 0.
  - State goes to HOLD.
- start=1 in SHIFT aborts the frame.
  - The shift register and bit_count are cleared and the state stays SHIFT.
  - bit_valid in that cycle is discarded.
  - data_out is unchanged.
- HOLD:
  - out_valid stays 1. data_out is held. bit_valid is ignored.
  - Handshake (out_valid & out_ready) → out_valid <= 0, go to IDLE.
  - If start=1 in the handshake cycle, go directly to SHIFT with a cleared frame.
  - start without out_ready is ignored.
- data_out changes only at frame completion. Partial frames are never visible on it.
- busy = (state == SHIFT).
- rst=1 has priority over every other input in any state, including mid-frame and in HOLD.

## Timing
- Reset values: data_out=0, out_valid=0, busy=0, bit_count=0, shreg=0, state IDLE.
- start→busy: 1 cycle. busy is high after the edge that samples start.
- Completion latency:
  - out_valid and the new data_out are visible right after the edge that samples the WIDTH-th valid bit.
  - A gap-free frame therefore takes WIDTH+1 edges from start.
- Throughput: one word per WIDTH+1 cycles minimum, including the start cycle. Gaps in bit_valid extend the frame arbitrarily.
- bit_count counts 0..WIDTH-1 in SHIFT. It never shows WIDTH.
- out_valid drops on the edge after a handshake. It stays stable indefinitely under back-pressure.
- Simultaneous start, bit_valid and out_ready in HOLD: the handshake completes and a new frame opens. The bit is not captured.

## Structure
- Shared package bit_serial_pkg:
  - state enum (IDLE, SHIFT, HOLD)
  - DEFAULT_WIDTH = 8, shared with the serial source and adder
- Single module, no sub-modules. Shift register, counter and FSM are small enough to live together.
- The counter end-of-frame compare (bit_count == WIDTH-1 & bit_valid) is one shared signal used by both the FSM and the data_out load.

## Test plan
- Reset:
  - Drive rst=1 for 2 cycles with random inputs.
  - Require data_out=0, out_valid=0, busy=0 and bit_count=0 after each edge.
- Basic frame:
  - Pulse start, then send bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles with bit_valid=1.
  - Require out_valid=1 and data_out=8'h4D right after the 8th edge.
  - Require busy=0 in HOLD.
- Gaps:
  - Send the same stream with bit_valid=0 for 3 cycles after bit 4.
  - Require bit_count to hold at 4 during the gap.
  - Require the final data_out=8'h4D.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after completion while toggling bit_in and bit_valid.
  - Require out_valid=1 and data_out=8'h4D to stay stable.
  - Raise out_ready; require out_valid=0 on the next edge and state IDLE.
- Restart:
  - After 3 bits, pulse start again, then send 8 ones.
  - Require data_out=8'hFF, with no residue from the aborted frame.
- Mid-frame reset:
  - Assert rst after 5 bits.
  - Then send 8 bits with bit_valid=1 and no start.
  - Require bit_count=0, out_valid=0 and data_out=0 throughout.
